// File: rtl/csa_acc_pkg.sv
// rtl/csa_acc_pkg.sv - shared types and parameter helpers for the CSA accumulator
package csa_acc_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  // Eight guard bits allow 256 full-scale operands before the total wraps
  function automatic int default_acc_width(int w);
    return w + 8;
  endfunction

endpackage

// File: rtl/CarrySaveAdder.sv
// rtl/CarrySaveAdder.sv - 3:2 carry-save compressor, one full adder per bit
module CarrySaveAdder #(
  parameter int Width = 16
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [Width-1:0] c_i,
  output logic [Width-1:0] sum_o,
  output logic [Width-1:0] carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - streaming packet accumulator, redundant sum/carry total
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int Width    = 8,
  parameter int AccWidth = default_acc_width(Width),
  parameter int CntWidth = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [Width-1:0]    in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [AccWidth-1:0] out_sum,
  output logic [CntWidth-1:0] out_count,
  output logic                out_cnt_sat
);

  state_e              state_q, state_d;
  logic [AccWidth-1:0] sum_q, sum_d, carry_q, carry_d;
  logic [AccWidth-1:0] out_sum_q, out_sum_d;
  logic [CntWidth-1:0] count_q, count_d, out_count_q, out_count_d;
  logic                sat_q, sat_d, out_sat_q, out_sat_d;
  logic                in_ready_q, out_valid_q;
  logic [AccWidth-1:0] carry_shl, data_ext, csa_sum, csa_carry;
  logic                beat, handshake;

  // Running total is sum_q + 2*carry_q; the shift drops the carry MSB (mod 2^AccWidth)
  assign carry_shl = carry_q << 1;
  assign data_ext  = AccWidth'(in_data);
  assign beat      = in_valid & in_ready_q;
  assign handshake = out_valid_q & out_ready;

  CarrySaveAdder #(
    .Width(AccWidth)
  ) u_csa (
    .a_i    (sum_q),
    .b_i    (carry_shl),
    .c_i    (data_ext),
    .sum_o  (csa_sum),
    .carry_o(csa_carry)
  );

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    count_d     = count_q;
    sat_d       = sat_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (beat) begin
          sum_d   = csa_sum;
          carry_d = csa_carry;
          if (count_q == {CntWidth{1'b1}}) sat_d = 1'b1;
          else count_d = count_q + CntWidth'(1);
          state_d = in_last ? S_RESOLVE : S_ACCUM;
        end
      end
      S_RESOLVE: begin
        out_sum_d   = sum_q + carry_shl;
        out_count_d = count_q;
        out_sat_d   = sat_q;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (handshake) begin
          sum_d   = '0;
          carry_d = '0;
          count_d = '0;
          sat_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track state_q exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      carry_q     <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
      in_ready_q  <= (state_d == S_IDLE) || (state_d == S_ACCUM);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_sum     = out_sum_q;
  assign out_count   = out_count_q;
  assign out_cnt_sat = out_sat_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - directed-vector bench for csa_accumulator
module tb_csa_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index 0: Width=8/AccWidth=16/CntWidth=8, 1: AccWidth=9, 2: CntWidth=2
  logic        iv[3], il[3], ordy[3];
  logic [7:0]  id[3];
  logic        ird[3], ov[3], osat[3];
  logic [15:0] osum[3];
  logic [7:0]  ocnt[3];
  logic [15:0] osum0, osum2;
  logic [8:0]  osum1;
  logic [7:0]  ocnt0, ocnt1;
  logic [1:0]  ocnt2;

  assign osum[0] = osum0;
  assign osum[1] = {7'd0, osum1};
  assign osum[2] = osum2;
  assign ocnt[0] = ocnt0;
  assign ocnt[1] = ocnt1;
  assign ocnt[2] = {6'd0, ocnt2};

  csa_accumulator #(.Width(8), .AccWidth(16), .CntWidth(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ird[0]), .in_data(id[0]),
    .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(osum0),
    .out_count(ocnt0), .out_cnt_sat(osat[0]));

  csa_accumulator #(.Width(8), .AccWidth(9), .CntWidth(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ird[1]), .in_data(id[1]),
    .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(osum1),
    .out_count(ocnt1), .out_cnt_sat(osat[1]));

  csa_accumulator #(.Width(8), .AccWidth(16), .CntWidth(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ird[2]), .in_data(id[2]),
    .in_last(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(osum2),
    .out_count(ocnt2), .out_cnt_sat(osat[2]));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and return just after the edge that accepts it
  task automatic send(input int k, input logic [7:0] d, input logic l);
    int waited;
    iv[k] = 1'b1;
    id[k] = d;
    il[k] = l;
    waited = 0;
    while (!ird[k] && waited < 20) begin
      step();
      waited++;
    end
    if (waited >= 20) check("ready_timeout", 32'd0, 32'd1);
    step();
    iv[k] = 1'b0;
    il[k] = 1'b0;
  endtask

  // Called right after the last beat is accepted (state RESOLVE)
  task automatic expect_result(input int k, input int s, input int c, input int sat);
    check("resolve_no_valid", ov[k], 0);
    check("resolve_not_ready", ird[k], 0);
    step();
    check("done_valid", ov[k], 1);
    check("sum", osum[k], s);
    check("count", ocnt[k], c);
    check("sat", osat[k], sat);
    check("done_not_ready", ird[k], 0);
    if (ordy[k]) begin
      step();
      check("valid_pulse_end", ov[k], 0);
      check("idle_ready", ird[k], 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; il[k] = 1'b0; id[k] = 8'd0; ordy[k] = 1'b1;
    end
    repeat (2) step();
    check("rst_in_ready", ird[0], 0);
    check("rst_out_valid", ov[0], 0);
    check("rst_sum", osum[0], 0);
    check("rst_count", ocnt[0], 0);
    check("rst_sat", osat[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", ird[0], 1);

    // 10+20+30 back to back
    send(0, 8'd10, 1'b0);
    send(0, 8'd20, 1'b0);
    send(0, 8'd30, 1'b1);
    expect_result(0, 60, 3, 0);

    // single-beat packet
    send(0, 8'd255, 1'b1);
    expect_result(0, 255, 1, 0);

    // 9-bit accumulator wraps: 765 mod 512
    send(1, 8'd255, 1'b0);
    send(1, 8'd255, 1'b0);
    send(1, 8'd255, 1'b1);
    expect_result(1, 253, 3, 0);

    // 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) send(2, 8'd1, (i == 4));
    expect_result(2, 5, 3, 1);
    send(2, 8'd1, 1'b1);
    expect_result(2, 1, 1, 0);

    // backpressure with a pending beat of 7
    ordy[0] = 1'b0;
    send(0, 8'd1, 1'b1);
    expect_result(0, 1, 1, 0);
    iv[0] = 1'b1; id[0] = 8'd7; il[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid_held", ov[0], 1);
      check("bp_sum_held", osum[0], 1);
      check("bp_not_ready", ird[0], 0);
    end
    ordy[0] = 1'b1;
    step();
    check("bp_released", ov[0], 0);
    check("bp_ready_again", ird[0], 1);
    step();
    iv[0] = 1'b0; il[0] = 1'b0;
    expect_result(0, 7, 1, 0);

    // async reset mid-packet discards the partial sum
    send(0, 8'd100, 1'b0);
    send(0, 8'd50, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sum", osum[0], 0);
    check("arst_count", ocnt[0], 0);
    check("arst_valid", ov[0], 0);
    check("arst_ready", ird[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("arst_ready_back", ird[0], 1);
    send(0, 8'd4, 1'b1);
    expect_result(0, 4, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
